// File: rtl/id_ex_stage.sv
// id_ex_stage: single-entry ID/EX pipeline register with valid/ready handshake and ALU control decode.
// Define FORWARDING_EN to resolve rs1/rs2 operands from EX/MEM and MEM/WB results at capture time.
module id_ex_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    output logic             outValid,
    input  logic             outReady,
    input  logic             flush,
    input  logic [WIDTH-1:0] readData1,
    input  logic [WIDTH-1:0] readData2,
    input  logic [WIDTH-1:0] immediate,
    input  logic [1:0]       ALUOp,
    input  logic [2:0]       funct3,
    input  logic             funct7Bit30,
    input  logic             ALUSrc,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    input  logic [4:0]       ctrlIn,
    input  logic [4:0]       exMemRd,
    input  logic             exMemRegWrite,
    input  logic [WIDTH-1:0] exMemResult,
    input  logic [4:0]       memWbRd,
    input  logic             memWbRegWrite,
    input  logic [WIDTH-1:0] memWbResult,
    output logic [WIDTH-1:0] input1,
    output logic [WIDTH-1:0] input2,
    output logic [3:0]       ALUControlInput,
    output logic [WIDTH-1:0] storeData,
    output logic [4:0]       rdOut,
    output logic [4:0]       ctrlOut
);
    logic             capture;
    logic             hold;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [3:0]       alu_dec;

    assign inReady = !outValid || outReady;
    assign capture = inValid && inReady && !flush;
    assign hold    = outValid && !outReady && !flush;

`ifdef FORWARDING_EN
    // EX/MEM is the younger result, so it wins over MEM/WB
    always_comb begin
        op1 = (exMemRegWrite && exMemRd != 5'd0 && exMemRd == rs1) ? exMemResult :
              (memWbRegWrite && memWbRd != 5'd0 && memWbRd == rs1) ? memWbResult : readData1;
        op2 = (exMemRegWrite && exMemRd != 5'd0 && exMemRd == rs2) ? exMemResult :
              (memWbRegWrite && memWbRd != 5'd0 && memWbRd == rs2) ? memWbResult : readData2;
    end
`else
    logic unused_fwd;
    assign op1 = readData1;
    assign op2 = readData2;
    assign unused_fwd = ^{rs1, rs2, exMemRd, exMemRegWrite, exMemResult, memWbRd, memWbRegWrite, memWbResult};
`endif

    always_comb begin
        alu_dec = (ALUOp == 2'b00) ? 4'b0010 :
                  (ALUOp == 2'b01) ? 4'b0110 :
                  (ALUOp == 2'b11) ? 4'b1111 :
                  (funct3 == 3'b000) ? (funct7Bit30 ? 4'b0110 : 4'b0010) :
                  (funct3 == 3'b111) ? 4'b0000 :
                  (funct3 == 3'b110) ? 4'b0001 : 4'b1111;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid        <= 1'b0;
            ctrlOut         <= '0;
            input1          <= '0;
            input2          <= '0;
            storeData       <= '0;
            rdOut           <= '0;
            ALUControlInput <= '0;
        end else begin
            outValid <= capture || hold;
            // control bits are zeroed whenever the slot empties so nothing downstream fires
            ctrlOut  <= capture ? ctrlIn : hold ? ctrlOut : '0;
            if (capture) begin
                input1          <= op1;
                input2          <= ALUSrc ? immediate : op2;
                storeData       <= op2;
                rdOut           <= rd;
                ALUControlInput <= alu_dec;
            end
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
    localparam int WIDTH = 64;
    logic clk = 1'b0, rst_n = 1'b0;
    logic inValid = 0, inReady, outValid, outReady = 0, flush = 0;
    logic [WIDTH-1:0] readData1 = '0, readData2 = '0, immediate = '0;
    logic [1:0] ALUOp = '0;
    logic [2:0] funct3 = '0;
    logic funct7Bit30 = 0, ALUSrc = 0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0, ctrlIn = '0;
    logic [4:0] exMemRd = '0, memWbRd = '0;
    logic exMemRegWrite = 0, memWbRegWrite = 0;
    logic [WIDTH-1:0] exMemResult = '0, memWbResult = '0;
    logic [WIDTH-1:0] input1, input2, storeData;
    logic [3:0] ALUControlInput;
    logic [4:0] rdOut, ctrlOut;
    int checks = 0, fails = 0;

    id_ex_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady), .outValid(outValid),
        .outReady(outReady), .flush(flush), .readData1(readData1), .readData2(readData2),
        .immediate(immediate), .ALUOp(ALUOp), .funct3(funct3), .funct7Bit30(funct7Bit30),
        .ALUSrc(ALUSrc), .rs1(rs1), .rs2(rs2), .rd(rd), .ctrlIn(ctrlIn), .exMemRd(exMemRd),
        .exMemRegWrite(exMemRegWrite), .exMemResult(exMemResult), .memWbRd(memWbRd),
        .memWbRegWrite(memWbRegWrite), .memWbResult(memWbResult), .input1(input1),
        .input2(input2), .ALUControlInput(ALUControlInput), .storeData(storeData),
        .rdOut(rdOut), .ctrlOut(ctrlOut)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic b30, input logic src,
                         input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                         input logic [WIDTH-1:0] imm, input logic [4:0] r, input logic [4:0] c);
        inValid = 1; ALUOp = op; funct3 = f3; funct7Bit30 = b30; ALUSrc = src;
        readData1 = d1; readData2 = d2; immediate = imm; rd = r; ctrlIn = c;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (outValid !== 1'b0) begin fails++; $display("FAIL reset_outValid got %b exp 0", outValid); end
        checks++; if (inReady !== 1'b1) begin fails++; $display("FAIL reset_inReady got %b exp 1", inReady); end
        checks++; if (input1 !== '0) begin fails++; $display("FAIL reset_input1 got %h exp 0", input1); end
        checks++; if (ALUControlInput !== 4'b0000) begin fails++; $display("FAIL reset_alu got %b exp 0000", ALUControlInput); end
        checks++; if (ctrlOut !== 5'b0) begin fails++; $display("FAIL reset_ctrl got %b exp 00000", ctrlOut); end
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_sub();
        outReady = 1;
        drive(2'b10, 3'b000, 1, 0, 64'd9, 64'd4, 64'd0, 5'd3, 5'b00001);
        step();
        inValid = 0;
        checks++; if (outValid !== 1'b1) begin fails++; $display("FAIL sub_outValid got %b exp 1", outValid); end
        checks++; if (ALUControlInput !== 4'b0110) begin fails++; $display("FAIL sub_alu got %b exp 0110", ALUControlInput); end
        checks++; if (input1 !== 64'd9) begin fails++; $display("FAIL sub_input1 got %h exp 9", input1); end
        checks++; if (input2 !== 64'd4) begin fails++; $display("FAIL sub_input2 got %h exp 4", input2); end
        checks++; if (rdOut !== 5'd3) begin fails++; $display("FAIL sub_rd got %d exp 3", rdOut); end
        checks++; if (ctrlOut !== 5'b00001) begin fails++; $display("FAIL sub_ctrl got %b exp 00001", ctrlOut); end
        step();
        checks++; if (outValid !== 1'b0) begin fails++; $display("FAIL drain_outValid got %b exp 0", outValid); end
        checks++; if (ctrlOut !== 5'b0) begin fails++; $display("FAIL drain_ctrl got %b exp 00000", ctrlOut); end
        checks++; if (input1 !== 64'd9) begin fails++; $display("FAIL drain_input1 got %h exp 9", input1); end
    endtask

    task automatic test_imm();
        drive(2'b00, 3'b000, 0, 1, 64'd1, 64'h55, 64'hFFFF_FFFF_FFFF_FFF8, 5'd7, 5'b01010);
        step();
        inValid = 0;
        checks++; if (ALUControlInput !== 4'b0010) begin fails++; $display("FAIL imm_alu got %b exp 0010", ALUControlInput); end
        checks++; if (input2 !== 64'hFFFF_FFFF_FFFF_FFF8) begin fails++; $display("FAIL imm_input2 got %h exp fffffffffffffff8", input2); end
        checks++; if (storeData !== 64'h55) begin fails++; $display("FAIL imm_store got %h exp 55", storeData); end
        step();
    endtask

    task automatic test_decode();
        logic [1:0] ops [8] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
        logic [2:0] f3s [8] = '{3'b101, 3'b000, 3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b000};
        logic       bts [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] exp [8] = '{4'b0010, 4'b0110, 4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1111, 4'b1111};
        for (int i = 0; i < 8; i++) begin
            drive(ops[i], f3s[i], bts[i], 0, 64'd0, 64'd0, 64'd0, 5'd1, 5'b0);
            step();
            checks++; if (ALUControlInput !== exp[i]) begin fails++; $display("FAIL decode_%0d got %b exp %b", i, ALUControlInput, exp[i]); end
        end
        inValid = 0;
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 3'b000, 0, 0, 64'(100 + i), 64'd0, 64'd0, 5'd2, 5'b00001);
            step();
            checks++; if (outValid !== 1'b1 || input1 !== 64'(100 + i)) begin
                fails++; $display("FAIL b2b_%0d got v=%b in1=%0d exp v=1 in1=%0d", i, outValid, input1, 100 + i);
            end
        end
        inValid = 0;
        step();
    endtask

    task automatic test_stall();
        outReady = 1;
        drive(2'b01, 3'b000, 0, 0, 64'hA, 64'hA1, 64'd0, 5'd4, 5'b00011);
        step();
        outReady = 0;
        drive(2'b00, 3'b000, 0, 0, 64'hB, 64'hB1, 64'd0, 5'd5, 5'b00101);
        #1;
        checks++; if (inReady !== 1'b0) begin fails++; $display("FAIL stall_inReady got %b exp 0", inReady); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (outValid !== 1'b1 || input1 !== 64'hA || ALUControlInput !== 4'b0110 || ctrlOut !== 5'b00011 || rdOut !== 5'd4) begin
                fails++; $display("FAIL stall_hold_%0d got v=%b in1=%h alu=%b ctrl=%b rd=%0d exp v=1 in1=a alu=0110 ctrl=00011 rd=4",
                                  i, outValid, input1, ALUControlInput, ctrlOut, rdOut);
            end
        end
        outReady = 1;
        #1;
        checks++; if (inReady !== 1'b1) begin fails++; $display("FAIL stall_release_inReady got %b exp 1", inReady); end
        step();
        inValid = 0;
        checks++; if (outValid !== 1'b1 || input1 !== 64'hB || ctrlOut !== 5'b00101 || ALUControlInput !== 4'b0010) begin
            fails++; $display("FAIL stall_new got v=%b in1=%h ctrl=%b alu=%b exp v=1 in1=b ctrl=00101 alu=0010", outValid, input1, ctrlOut, ALUControlInput);
        end
        step();
    endtask

    task automatic test_flush();
        outReady = 1;
        drive(2'b00, 3'b000, 0, 0, 64'h10, 64'd0, 64'd0, 5'd6, 5'b11111);
        step();
        drive(2'b01, 3'b000, 0, 0, 64'h20, 64'd0, 64'd0, 5'd8, 5'b00001);
        flush = 1;
        step();
        flush = 0; inValid = 0;
        checks++; if (outValid !== 1'b0) begin fails++; $display("FAIL flush_outValid got %b exp 0", outValid); end
        checks++; if (ctrlOut !== 5'b0) begin fails++; $display("FAIL flush_ctrl got %b exp 00000", ctrlOut); end
        checks++; if (input1 !== 64'h10 || rdOut !== 5'd6) begin fails++; $display("FAIL flush_nocapture got in1=%h rd=%0d exp in1=10 rd=6", input1, rdOut); end
        step();
    endtask

    task automatic test_forwarding();
        logic [WIDTH-1:0] e1, e2;
`ifdef FORWARDING_EN
        e1 = 64'h77; e2 = 64'h11;
`else
        e1 = 64'h33; e2 = 64'h33;
`endif
        outReady = 1;
        rs1 = 5'd5; exMemRd = 5'd5; exMemRegWrite = 1; exMemResult = 64'h77;
        memWbRd = 5'd5; memWbRegWrite = 1; memWbResult = 64'h11;
        drive(2'b00, 3'b000, 0, 0, 64'h33, 64'h44, 64'd0, 5'd9, 5'b00001);
        step();
        checks++; if (input1 !== e1) begin fails++; $display("FAIL fwd_exmem got %h exp %h", input1, e1); end
        exMemRd = 5'd0;
        step();
        inValid = 0;
        checks++; if (input1 !== e2) begin fails++; $display("FAIL fwd_memwb got %h exp %h", input1, e2); end
        checks++; if (storeData !== 64'h44) begin fails++; $display("FAIL fwd_store got %h exp 44", storeData); end
        exMemRegWrite = 0; memWbRegWrite = 0; rs1 = 5'd0; memWbRd = 5'd0;
        step();
    endtask

    task automatic test_async_reset();
        outReady = 0;
        drive(2'b01, 3'b000, 0, 0, 64'h99, 64'd0, 64'd0, 5'd12, 5'b00111);
        step();
        inValid = 0;
        checks++; if (outValid !== 1'b1) begin fails++; $display("FAIL areset_pre got %b exp 1", outValid); end
        #2 rst_n = 0;
        #1;
        checks++; if (outValid !== 1'b0 || ctrlOut !== 5'b0 || input1 !== '0 || rdOut !== 5'd0 || ALUControlInput !== 4'b0) begin
            fails++; $display("FAIL areset_clear got v=%b ctrl=%b in1=%h rd=%0d alu=%b exp all 0", outValid, ctrlOut, input1, rdOut, ALUControlInput);
        end
        checks++; if (inReady !== 1'b1) begin fails++; $display("FAIL areset_inReady got %b exp 1", inReady); end
        step();
        rst_n = 1;
        outReady = 1;
        drive(2'b11, 3'b000, 0, 0, 64'd1, 64'd2, 64'd0, 5'd1, 5'b00001);
        step();
        inValid = 0;
        checks++; if (ALUControlInput !== 4'b1111 || outValid !== 1'b1) begin
            fails++; $display("FAIL areset_op11 got alu=%b v=%b exp alu=1111 v=1", ALUControlInput, outValid);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_sub();
        test_imm();
        test_decode();
        test_back_to_back();
        test_stall();
        test_flush();
        test_forwarding();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
